// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state encoding and widths for the AD7643 sequencer
package adc_pkg;

  localparam int SAMP_W = 18;
  localparam int ADR_W  = 14;
  localparam int DATA_W = SAMP_W - 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNV    = 3'd1,
    S_WAITB  = 3'd2,
    S_SHIFT  = 3'd3,
    S_STORE0 = 3'd4,
    S_STORE1 = 3'd5,
    S_GAPW   = 3'd6
  } adc_state_t;

endpackage

// File: rtl/adc_serial_rx.sv
// rtl/adc_serial_rx.sv - ADSCLK generator and dual 18-bit MSB-first shifter
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              clr,
  input  logic              sdout0,
  input  logic              sdout1,
  output logic              sclk,
  output logic              done,
  output logic [SAMP_W-1:0] word0,
  output logic [SAMP_W-1:0] word1
);

  logic       active_q;
  logic [7:0] hcnt_q;
  logic [4:0] bcnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      active_q <= 1'b0;
      sclk     <= 1'b0;
      done     <= 1'b0;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      word0    <= '0;
      word1    <= '0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        active_q <= 1'b0;
        sclk     <= 1'b0;
        hcnt_q   <= '0;
        bcnt_q   <= '0;
      end else if (start) begin
        active_q <= 1'b1;
        sclk     <= 1'b0;
        hcnt_q   <= '0;
        bcnt_q   <= '0;
        word0    <= '0;
        word1    <= '0;
      end else if (active_q) begin
        if (hcnt_q == 8'(SCLK_HALF - 1)) begin
          hcnt_q <= '0;
          // data is captured on the same CLK edge that raises ADSCLK
          if (!sclk) begin
            sclk  <= 1'b1;
            word0 <= {word0[SAMP_W-2:0], sdout0};
            word1 <= {word1[SAMP_W-2:0], sdout1};
          end else begin
            sclk <= 1'b0;
            if (bcnt_q == 5'(SAMP_W - 1)) begin
              active_q <= 1'b0;
              done     <= 1'b1;
            end else begin
              bcnt_q <= bcnt_q + 5'd1;
            end
          end
        end else begin
          hcnt_q <= hcnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - dual AD7643 conversion sequencer writing samples to memory
module adc_seq_ctrl
  import adc_pkg::*;
#(
  parameter int CNV_LOW   = 4,
  parameter int SCLK_HALF = 2,
  parameter int BUSY_TMO  = 512,
  parameter int GAP       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADR_W-1:0]  NSAMP,
  input  logic [ADR_W-1:0]  BASE,
  input  logic              ADBUSY0,
  input  logic              ADBUSY1,
  input  logic              ADSDOUT0,
  input  logic              ADSDOUT1,
  output logic              ADCNVST,
  output logic              ADCS,
  output logic              ADSCLK,
  output logic              WEN,
  output logic [ADR_W-1:0]  WADR,
  output logic [DATA_W-1:0] WDATA,
  output logic              RUN,
  output logic              DONE,
  output logic              ERR
);

  adc_state_t        state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic              seen0_q, seen1_q;
  logic [ADR_W-1:0]  nsamp_q, adr_q, cnt_q;
  logic [SAMP_W-1:0] word0, word1;
  logic              rx_start, rx_done;
  logic              accept, abort_run, wr0, wr1, done_set, err_set;

  assign accept    = (state_q == S_IDLE) && START && !ABORT;
  assign abort_run = (state_q != S_IDLE) && ABORT;

  adc_serial_rx #(.SCLK_HALF(SCLK_HALF)) u_rx (
    .CLK    (CLK),
    .RST    (RST),
    .start  (rx_start),
    .clr    (abort_run),
    .sdout0 (ADSDOUT0),
    .sdout1 (ADSDOUT1),
    .sclk   (ADSCLK),
    .done   (rx_done),
    .word0  (word0),
    .word1  (word1)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + 16'd1;
    rx_start = 1'b0;
    wr0      = 1'b0;
    wr1      = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (abort_run) begin
      state_d  = S_IDLE;
      done_set = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmr_d = '0;
          if (accept) begin
            if (NSAMP == '0) done_set = 1'b1;
            else             state_d  = S_CNV;
          end
        end
        S_CNV: begin
          if (tmr_q == 16'(CNV_LOW - 1)) begin
            state_d = S_WAITB;
            tmr_d   = '0;
          end
        end
        S_WAITB: begin
          if (seen0_q && seen1_q && !ADBUSY0 && !ADBUSY1) begin
            state_d  = S_SHIFT;
            rx_start = 1'b1;
            tmr_d    = '0;
          end else if (tmr_q == 16'(BUSY_TMO - 1)) begin
            state_d  = S_IDLE;
            err_set  = 1'b1;
            done_set = 1'b1;
          end
        end
        S_SHIFT: begin
          if (rx_done) begin
            state_d = S_STORE0;
            tmr_d   = '0;
          end
        end
        // each store state spends two cycles so WEN always has a low cycle between writes
        S_STORE0: begin
          if (tmr_q == '0) begin
            wr0 = 1'b1;
          end else begin
            state_d = S_STORE1;
            tmr_d   = '0;
          end
        end
        S_STORE1: begin
          if (tmr_q == '0) begin
            wr1 = 1'b1;
          end else if (cnt_q == nsamp_q) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end else begin
            state_d = S_GAPW;
            tmr_d   = '0;
          end
        end
        S_GAPW: begin
          if (tmr_q == 16'(GAP - 1)) begin
            state_d = S_CNV;
            tmr_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      seen0_q <= 1'b0;
      seen1_q <= 1'b0;
      nsamp_q <= '0;
      adr_q   <= '0;
      cnt_q   <= '0;
      ADCNVST <= 1'b1;
      ADCS    <= 1'b1;
      WEN     <= 1'b0;
      WADR    <= '0;
      WDATA   <= '0;
      RUN     <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      seen0_q <= (state_q == S_WAITB) && (seen0_q || ADBUSY0);
      seen1_q <= (state_q == S_WAITB) && (seen1_q || ADBUSY1);
      if (accept) begin
        nsamp_q <= NSAMP;
        adr_q   <= BASE;
        cnt_q   <= '0;
      end
      if (wr0 || wr1) adr_q <= adr_q + 14'd1;
      if (wr1)        cnt_q <= cnt_q + 14'd1;
      ADCNVST <= (state_d != S_CNV);
      ADCS    <= !(state_d inside {S_CNV, S_WAITB, S_SHIFT});
      RUN     <= (state_d != S_IDLE);
      DONE    <= done_set;
      WEN     <= wr0 || wr1;
      if (wr0 || wr1) begin
        WADR  <= adr_q;
        WDATA <= wr0 ? word0[SAMP_W-1:2] : word1[SAMP_W-1:2];
      end
      if (accept)       ERR <= 1'b0;
      else if (err_set) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb/tb_adc_seq_ctrl.sv - directed self-checking bench for adc_seq_ctrl
module tb_adc_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST, START, ABORT;
  logic [13:0] NSAMP, BASE;
  logic        ADBUSY0, ADBUSY1, ADSDOUT0, ADSDOUT1;
  logic        ADCNVST, ADCS, ADSCLK, WEN, RUN, DONE, ERR;
  logic [13:0] WADR;
  logic [15:0] WDATA;

  adc_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .NSAMP(NSAMP), .BASE(BASE),
    .ADBUSY0(ADBUSY0), .ADBUSY1(ADBUSY1), .ADSDOUT0(ADSDOUT0), .ADSDOUT1(ADSDOUT1),
    .ADCNVST(ADCNVST), .ADCS(ADCS), .ADSCLK(ADSCLK), .WEN(WEN), .WADR(WADR),
    .WDATA(WDATA), .RUN(RUN), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ADC model: BUSY pulses after CNVST, data bits presented MSB-first per ADSCLK rise
  logic [17:0] w0, w1;
  logic        busy_en;
  logic [4:0]  bitn, sel;
  logic [15:0] bcyc;
  logic        adc_sclk_prev;

  initial begin
    bitn = '0; bcyc = '0; adc_sclk_prev = 1'b0;
  end

  always @(negedge CLK) begin
    if (!ADCNVST) begin
      bitn = '0;
      bcyc = '0;
    end else begin
      bcyc = bcyc + 16'd1;
      if (ADSCLK && !adc_sclk_prev) bitn = bitn + 5'd1;
    end
    adc_sclk_prev = ADSCLK;
  end

  assign sel      = 5'd17 - bitn;
  assign ADBUSY0  = busy_en && (bcyc >= 16'd2) && (bcyc < 16'd8);
  assign ADBUSY1  = busy_en && (bcyc >= 16'd3) && (bcyc < 16'd10);
  assign ADSDOUT0 = (bitn < 5'd18) ? w0[sel] : 1'b0;
  assign ADSDOUT1 = (bitn < 5'd18) ? w1[sel] : 1'b0;

  // output monitor
  logic [13:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          done_cnt, cnv_lo, b2b, sclk_rises;
  logic        wen_prev, mon_sclk_prev;

  always @(negedge CLK) begin
    if (WEN) begin
      wa_q.push_back(WADR);
      wd_q.push_back(WDATA);
    end
    if (WEN && wen_prev) b2b++;
    wen_prev = WEN;
    if (DONE) done_cnt++;
    if (!ADCNVST) cnv_lo++;
    if (ADSCLK && !mon_sclk_prev) sclk_rises++;
    mon_sclk_prev = ADSCLK;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0; cnv_lo = 0; b2b = 0; sclk_rises = 0;
  endtask

  task automatic start_run(input logic [13:0] ns, input logic [13:0] base);
    NSAMP = ns;
    BASE  = base;
    START = 1'b1;
    tick(1);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin
      tick(1);
      n++;
    end
    chk(tag, done_cnt != 0, 1);
  endtask

  logic [13:0] exp_adr[6];
  int          n;
  logic        seen_low;

  initial begin
    wen_prev = 1'b0; mon_sclk_prev = 1'b0;
    clear_mon();
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; NSAMP = '0; BASE = '0;
    busy_en = 1'b1; w0 = '0; w1 = '0;
    tick(3);
    chk("rst_ctl", {ADCNVST, ADCS, ADSCLK, WEN, RUN, DONE, ERR}, 7'b1100000);
    chk("rst_wadr", WADR, 0);
    chk("rst_wdata", WDATA, 0);
    RST = 1'b0;
    tick(2);

    // single conversion, full-scale ch0 and small ch1
    clear_mon();
    w0 = 18'h3FFFF; w1 = 18'h00004;
    start_run(14'd1, 14'd100);
    chk("run_up", RUN, 1);
    wait_done("t1_done", 2000);
    tick(5);
    chk("t1_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("t1_a0", wa_q[0], 100);
      chk("t1_d0", wd_q[0], 16'hFFFF);
      chk("t1_a1", wa_q[1], 101);
      chk("t1_d1", wd_q[1], 16'h0001);
    end
    chk("t1_ndone", done_cnt, 1);
    chk("t1_run", RUN, 0);
    chk("t1_sclk", sclk_rises, 18);
    chk("t1_cnvlo", cnv_lo, 4);
    chk("t1_b2b", b2b, 0);

    // three conversions across the address wrap
    clear_mon();
    w0 = 18'h2A5A5; w1 = 18'h15A5A;
    start_run(14'd3, 14'd16382);
    wait_done("t2_done", 5000);
    tick(20);
    exp_adr[0] = 14'd16382; exp_adr[1] = 14'd16383; exp_adr[2] = 14'd0;
    exp_adr[3] = 14'd1;     exp_adr[4] = 14'd2;     exp_adr[5] = 14'd3;
    chk("t2_nwr", wa_q.size(), 6);
    if (wa_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t2_a%0d", i), wa_q[i], exp_adr[i]);
        chk($sformatf("t2_d%0d", i), wd_q[i], (i % 2 == 0) ? 16'hA969 : 16'h5696);
      end
    end
    chk("t2_ndone", done_cnt, 1);
    chk("t2_b2b", b2b, 0);
    chk("t2_cnvlo", cnv_lo, 12);

    // BUSY never rises: timeout after 512 cycles in WAITB
    clear_mon();
    busy_en = 1'b0;
    start_run(14'd1, 14'd0);
    n = 0;
    while (DONE !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("t3_lat", n, 516);
    chk("t3_err", ERR, 1);
    chk("t3_run", RUN, 0);
    tick(3);
    chk("t3_nwr", wa_q.size(), 0);
    chk("t3_err_sticky", ERR, 1);
    busy_en = 1'b1;

    // NSAMP=0: ERR cleared, DONE next cycle, no conversion
    clear_mon();
    start_run(14'd0, 14'd0);
    chk("t4_err_clr", ERR, 0);
    chk("t4_done", DONE, 1);
    chk("t4_run", RUN, 0);
    tick(10);
    chk("t4_cnvlo", cnv_lo, 0);
    chk("t4_ndone", done_cnt, 1);

    // START during a run is ignored
    clear_mon();
    w0 = 18'h3FFFF; w1 = 18'h00004;
    start_run(14'd1, 14'd200);
    tick(3);
    start_run(14'd5, 14'd500);
    wait_done("t5_done", 2000);
    tick(20);
    chk("t5_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) chk("t5_a1", wa_q[1], 201);
    chk("t5_ndone", done_cnt, 1);

    // START and ABORT together in IDLE
    clear_mon();
    NSAMP = 14'd1; START = 1'b1; ABORT = 1'b1;
    tick(1);
    START = 1'b0; ABORT = 1'b0;
    tick(2);
    chk("t6_run", RUN, 0);
    chk("t6_cnvlo", cnv_lo, 0);
    chk("t6_done", done_cnt, 0);

    // ABORT during the 9th ADSCLK period
    clear_mon();
    start_run(14'd1, 14'd0);
    n = 0;
    while (!(sclk_rises == 8 && ADSCLK == 1'b0) && n < 2000) begin
      tick(1);
      n++;
    end
    chk("t7_reach", n < 2000, 1);
    ABORT = 1'b1;
    tick(1);
    ABORT = 1'b0;
    chk("t7_ctl", {ADCS, ADCNVST, ADSCLK, DONE, RUN}, 5'b11010);
    tick(200);
    chk("t7_nwr", wa_q.size(), 0);
    chk("t7_ndone", done_cnt, 1);

    // RST in STORE0
    clear_mon();
    start_run(14'd1, 14'd0);
    n = 0;
    seen_low = 1'b0;
    while (!(seen_low && ADCS == 1'b1) && n < 2000) begin
      if (ADCS == 1'b0) seen_low = 1'b1;
      tick(1);
      n++;
    end
    chk("t8_reach", n < 2000, 1);
    RST = 1'b1;
    tick(1);
    chk("t8_ctl", {ADCNVST, ADCS, ADSCLK, WEN, RUN, DONE, ERR}, 7'b1100000);
    chk("t8_wadr", WADR, 0);
    chk("t8_wdata", WDATA, 0);
    RST = 1'b0;
    tick(30);
    chk("t8_nwr", wa_q.size(), 0);
    chk("t8_ndone", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
